dmem_arbiter: RTL

Shares the single data memory of the MIPS single-cycle core between the core's load/store port and an external loader/debug port. Core accesses have priority and complete in the same cycle. The external port is served in idle cycles or, after bounded starvation, by stalling the core. It also supports short locked bursts. The block sits between the core datapath and the data memory inside the top level.

---
 rtl/dmem_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the MIPS core load/store port and an external
// loader/debug port: core priority, bounded ext starvation, locked ext bursts.
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4,
  parameter int LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_stall,
  input  logic              x_req,
  input  logic              x_we,
  input  logic              x_lock,
  input  logic [ADDR_W-1:0] x_addr,
  input  logic [DATA_W-1:0] x_wdata,
  output logic              x_gnt,
  output logic [DATA_W-1:0] x_rdata,
  output logic              x_rvalid,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              owner
);

  typedef enum logic {OWN_CORE = 1'b0, OWN_EXT = 1'b1} own_e;

  own_e              state_q, state_d;
  logic [2:0]        starve_q, starve_d;
  logic [4:0]        lock_cnt_q, lock_cnt_d;
  logic              x_rvalid_q, x_rvalid_d;
  logic [DATA_W-1:0] x_rdata_q, x_rdata_d;
  logic              gnt_x, gnt_c;

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    lock_cnt_d = lock_cnt_q;
    x_rvalid_d = 1'b0;
    x_rdata_d  = x_rdata_q;
    gnt_x      = 1'b0;
    gnt_c      = 1'b0;
    c_stall    = 1'b0;

    if (!reset) begin
      if (state_q == OWN_EXT) begin
        gnt_x   = x_req;
        c_stall = c_req;
      end else begin
        gnt_x   = x_req && (!c_req || starve_q == 3'(MAX_WAIT));
        gnt_c   = c_req && !gnt_x;
        c_stall = c_req && gnt_x;
      end
    end

    if (x_req && !gnt_x)
      starve_d = (starve_q == 3'd7) ? starve_q : starve_q + 3'd1;
    else
      starve_d = 3'd0;

    if (gnt_x && !x_we) begin
      x_rvalid_d = 1'b1;
      x_rdata_d  = m_rdata;
    end

    // lock_cnt holds beats already taken in this burst; the beat that
    // completes LOCK_MAX is still performed and then ownership returns.
    case (state_q)
      OWN_CORE: begin
        if (gnt_x && x_lock) begin
          state_d    = OWN_EXT;
          lock_cnt_d = 5'd1;
        end
      end
      OWN_EXT: begin
        if (!x_req || !x_lock || lock_cnt_q == 5'(LOCK_MAX - 1)) begin
          state_d    = OWN_CORE;
          lock_cnt_d = 5'd0;
        end else begin
          lock_cnt_d = lock_cnt_q + 5'd1;
        end
      end
      default: state_d = OWN_CORE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= OWN_CORE;
      starve_q   <= 3'd0;
      lock_cnt_q <= 5'd0;
      x_rvalid_q <= 1'b0;
      x_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      lock_cnt_q <= lock_cnt_d;
      x_rvalid_q <= x_rvalid_d;
      x_rdata_q  <= x_rdata_d;
    end
  end

  assign m_we     = gnt_x ? x_we : (gnt_c & c_we);
  assign m_addr   = gnt_x ? x_addr : c_addr;
  assign m_wdata  = gnt_x ? x_wdata : c_wdata;
  assign c_rdata  = m_rdata;
  assign x_gnt    = gnt_x;
  assign x_rdata  = x_rdata_q;
  assign x_rvalid = x_rvalid_q;
  assign owner    = (state_q == OWN_EXT);

endmodule
